// File: rtl/wts_env_pkg.sv
// rtl/wts_env_pkg.sv - shared types and helpers for the multi-channel ADSR envelope generator
//
// Contents:
//   env_phase_t   envelope phase (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE), 3 bits
//   EV_PRI_*      event-priority constants; a larger value wins at service
//   env_event_t   resolved event for one channel service, encoded by priority
//   env_max()     full-scale envelope level for a given magnitude width
package wts_env_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_phase_t;

    localparam logic [1:0] EV_PRI_NONE    = 2'd0;
    localparam logic [1:0] EV_PRI_RELEASE = 2'd1;
    localparam logic [1:0] EV_PRI_ON      = 2'd2;
    localparam logic [1:0] EV_PRI_OFF     = 2'd3;

    typedef enum logic [1:0] {
        EV_NONE    = EV_PRI_NONE,
        EV_RELEASE = EV_PRI_RELEASE,
        EV_ON      = EV_PRI_ON,
        EV_OFF     = EV_PRI_OFF
    } env_event_t;

    function automatic int env_max(input int env_w);
        return 1 << env_w;
    endfunction

endpackage

// File: rtl/wts_env_step.sv
// rtl/wts_env_step.sv - combinational next-state calculator for one envelope channel
//
// Optional feature macro: WTS_ENV_EXP_DECAY_EN (exponential DECAY/SUSTAIN/RELEASE steps).
//
// Ports:
//   phase, level, cnt     current channel state
//   ev                    highest-priority pending event for this service
//   ar, dr, sr, rr        rate fields for this channel (0 = hold)
//   sl                    sustain level
//   nxt_phase, nxt_level, nxt_cnt   state after this service
module wts_env_step
    import wts_env_pkg::*;
#(
    parameter int ENV_W  = 7,
    parameter int RATE_W = 12
) (
    input  env_phase_t        phase,
    input  logic [ENV_W:0]    level,
    input  logic [RATE_W-1:0] cnt,
    input  env_event_t        ev,
    input  logic [RATE_W-1:0] ar,
    input  logic [RATE_W-1:0] dr,
    input  logic [RATE_W-1:0] sr,
    input  logic [RATE_W-1:0] rr,
    input  logic [ENV_W-1:0]  sl,
    output env_phase_t        nxt_phase,
    output logic [ENV_W:0]    nxt_level,
    output logic [RATE_W-1:0] nxt_cnt
);

    localparam logic [ENV_W:0]    LVL_MAX = (ENV_W+1)'(env_max(ENV_W));
    localparam logic [ENV_W:0]    LVL_ONE = (ENV_W+1)'(1);
    localparam logic [RATE_W-1:0] CNT_ONE = RATE_W'(1);
    localparam logic [RATE_W:0]   CNT_ONE_X = (RATE_W+1)'(1);

    logic [RATE_W-1:0] rate;
    logic              tick;
    logic [ENV_W:0]    sl_ext;
    logic [ENV_W:0]    floor_lvl;
    logic [ENV_W:0]    dec_amt;
    logic [ENV_W:0]    dec_lvl;

    assign sl_ext = {1'b0, sl};

    always_comb begin
        case (phase)
            ENV_ATTACK:  rate = ar;
            ENV_DECAY:   rate = dr;
            ENV_SUSTAIN: rate = sr;
            ENV_RELEASE: rate = rr;
            default:     rate = '0;
        endcase
    end

    // Compare one bit wider so counter+1 cannot wrap onto a small rate.
    assign tick = (rate != '0) && (({1'b0, cnt} + CNT_ONE_X) == {1'b0, rate});

    // Downward step, clamped at the phase floor (SL while decaying, else 0).
    always_comb begin
        floor_lvl = (phase == ENV_DECAY) ? sl_ext : '0;
`ifdef WTS_ENV_EXP_DECAY_EN
        dec_amt = (level >> 3) + LVL_ONE;
`else
        dec_amt = LVL_ONE;
`endif
        if ((level > floor_lvl) && ((level - floor_lvl) > dec_amt)) begin
            dec_lvl = level - dec_amt;
        end else begin
            dec_lvl = floor_lvl;
        end
    end

    always_comb begin
        nxt_phase = phase;
        nxt_level = level;
        nxt_cnt   = cnt;
        case (ev)
            EV_OFF: begin
                nxt_phase = ENV_IDLE;
                nxt_level = '0;
                nxt_cnt   = '0;
            end
            EV_ON: begin
                // Level is kept on retrigger so a re-keyed voice does not click.
                nxt_cnt = '0;
                if (ar == '0) begin
                    nxt_level = LVL_MAX;
                    nxt_phase = ENV_DECAY;
                end else begin
                    nxt_phase = ENV_ATTACK;
                end
            end
            EV_RELEASE: begin
                if (phase != ENV_IDLE) begin
                    nxt_phase = ENV_RELEASE;
                    nxt_cnt   = '0;
                end
            end
            default: begin
                if ((phase == ENV_DECAY) && (level <= sl_ext)) begin
                    nxt_phase = ENV_SUSTAIN;
                    nxt_cnt   = '0;
                end else if ((phase != ENV_IDLE) && (rate != '0)) begin
                    if (!tick) begin
                        nxt_cnt = cnt + CNT_ONE;
                    end else begin
                        nxt_cnt = '0;
                        if (phase == ENV_ATTACK) begin
                            if (level >= (LVL_MAX - LVL_ONE)) begin
                                nxt_level = LVL_MAX;
                                nxt_phase = ENV_DECAY;
                            end else begin
                                nxt_level = level + LVL_ONE;
                            end
                        end else begin
                            nxt_level = dec_lvl;
                            if (phase == ENV_DECAY) begin
                                if (dec_lvl <= sl_ext) nxt_phase = ENV_SUSTAIN;
                            end else if (dec_lvl == '0) begin
                                nxt_phase = ENV_IDLE;
                            end
                        end
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/wts_adsr_envelope_generator_mc.sv
// rtl/wts_adsr_envelope_generator_mc.sv - multi-channel ADSR envelope generator, one channel serviced per clk
//
// Optional feature macro: WTS_ENV_EXP_DECAY_EN (handled inside wts_env_step).
//
// Ports:
//   clk, nreset                       clock, asynchronous active-low reset
//   active                            sweep start pulse
//   key_on, key_release, key_off      per-channel event pulses, latched until serviced
//   reg_ar, reg_dr, reg_sr, reg_rr    per-channel rates, channel c at [c*RATE_W +: RATE_W]
//   reg_sl                            per-channel sustain level, channel c at [c*ENV_W +: ENV_W]
//   envelope                          per-channel level, channel c at [c*(ENV_W+1) +: ENV_W+1]
//   env_idle                          per-channel IDLE indicator
//   overrun                           one-clk pulse when active arrives mid-sweep
module wts_adsr_envelope_generator_mc
    import wts_env_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int ENV_W  = 7,
    parameter int RATE_W = 12
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      active,
    input  logic [CH_NUM-1:0]         key_on,
    input  logic [CH_NUM-1:0]         key_release,
    input  logic [CH_NUM-1:0]         key_off,
    input  logic [CH_NUM*RATE_W-1:0]  reg_ar,
    input  logic [CH_NUM*RATE_W-1:0]  reg_dr,
    input  logic [CH_NUM*RATE_W-1:0]  reg_sr,
    input  logic [CH_NUM*RATE_W-1:0]  reg_rr,
    input  logic [CH_NUM*ENV_W-1:0]   reg_sl,
    output logic [CH_NUM*(ENV_W+1)-1:0] envelope,
    output logic [CH_NUM-1:0]         env_idle,
    output logic                      overrun
);

    localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int LVL_W = ENV_W + 1;

    logic              busy;
    logic [CH_W-1:0]   sweep_ch;
    logic              svc_en;
    logic [CH_W-1:0]   svc_ch;
    logic [CH_NUM-1:0] svc_mask;

    logic [CH_NUM-1:0] pend_on, pend_rel, pend_off;
    logic [CH_NUM-1:0] ev_on_v, ev_rel_v, ev_off_v;
    env_event_t        svc_ev;

    env_phase_t        phase_q [CH_NUM];
    logic [LVL_W-1:0]  level_q [CH_NUM];
    logic [RATE_W-1:0] cnt_q   [CH_NUM];

    env_phase_t        nxt_phase;
    logic [LVL_W-1:0]  nxt_level;
    logic [RATE_W-1:0] nxt_cnt;

    // Channel 0 is serviced on the very clk that active starts the sweep.
    assign svc_en   = busy | active;
    assign svc_ch   = busy ? sweep_ch : '0;
    assign svc_mask = svc_en ? (CH_NUM'(1) << svc_ch) : '0;

    // Pulses arriving on the service clk are folded in so they are not lost.
    assign ev_on_v  = pend_on  | key_on;
    assign ev_rel_v = pend_rel | key_release;
    assign ev_off_v = pend_off | key_off;

    always_comb begin
        svc_ev = EV_NONE;
        if (ev_off_v[svc_ch])      svc_ev = EV_OFF;
        else if (ev_on_v[svc_ch])  svc_ev = EV_ON;
        else if (ev_rel_v[svc_ch]) svc_ev = EV_RELEASE;
    end

    wts_env_step #(
        .ENV_W  (ENV_W),
        .RATE_W (RATE_W)
    ) u_step (
        .phase     (phase_q[svc_ch]),
        .level     (level_q[svc_ch]),
        .cnt       (cnt_q[svc_ch]),
        .ev        (svc_ev),
        .ar        (reg_ar[svc_ch*RATE_W +: RATE_W]),
        .dr        (reg_dr[svc_ch*RATE_W +: RATE_W]),
        .sr        (reg_sr[svc_ch*RATE_W +: RATE_W]),
        .rr        (reg_rr[svc_ch*RATE_W +: RATE_W]),
        .sl        (reg_sl[svc_ch*ENV_W +: ENV_W]),
        .nxt_phase (nxt_phase),
        .nxt_level (nxt_level),
        .nxt_cnt   (nxt_cnt)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            busy     <= 1'b0;
            sweep_ch <= '0;
            overrun  <= 1'b0;
            pend_on  <= '0;
            pend_rel <= '0;
            pend_off <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                phase_q[i] <= ENV_IDLE;
                level_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            overrun <= active & busy;

            if (busy) begin
                if (sweep_ch == CH_W'(CH_NUM - 1)) begin
                    busy     <= 1'b0;
                    sweep_ch <= '0;
                end else begin
                    sweep_ch <= sweep_ch + CH_W'(1);
                end
            end else if (active && (CH_NUM > 1)) begin
                busy     <= 1'b1;
                sweep_ch <= CH_W'(1);
            end

            // Servicing a channel drops all its pending bits, including the losers.
            pend_on  <= ev_on_v  & ~svc_mask;
            pend_rel <= ev_rel_v & ~svc_mask;
            pend_off <= ev_off_v & ~svc_mask;

            if (svc_en) begin
                phase_q[svc_ch] <= nxt_phase;
                level_q[svc_ch] <= nxt_level;
                cnt_q[svc_ch]   <= nxt_cnt;
            end
        end
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_out
        assign envelope[c*LVL_W +: LVL_W] = level_q[c];
        assign env_idle[c]                = (phase_q[c] == ENV_IDLE);
    end

endmodule

// File: tb/tb_wts_adsr_envelope_generator_mc.sv
// tb/tb_wts_adsr_envelope_generator_mc.sv - scoreboard bench for the multi-channel ADSR envelope generator
module tb_wts_adsr_envelope_generator_mc;

    localparam int CH     = 4;
    localparam int ENV_W  = 7;
    localparam int RATE_W = 12;
    localparam int LVL_W  = ENV_W + 1;

    logic                   clk = 1'b0;
    logic                   nreset;
    logic                   active;
    logic [CH-1:0]          key_on, key_release, key_off;
    logic [CH*RATE_W-1:0]   reg_ar, reg_dr, reg_sr, reg_rr;
    logic [CH*ENV_W-1:0]    reg_sl;
    logic [CH*LVL_W-1:0]    envelope;
    logic [CH-1:0]          env_idle;
    logic                   overrun;

    wts_adsr_envelope_generator_mc #(
        .CH_NUM (CH),
        .ENV_W  (ENV_W),
        .RATE_W (RATE_W)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .active      (active),
        .key_on      (key_on),
        .key_release (key_release),
        .key_off     (key_off),
        .reg_ar      (reg_ar),
        .reg_dr      (reg_dr),
        .reg_sr      (reg_sr),
        .reg_rr      (reg_rr),
        .reg_sl      (reg_sl),
        .envelope    (envelope),
        .env_idle    (env_idle),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ch < 0 marks an overrun check; lvl then holds the expected overrun bit.
    typedef struct {
        int    at;
        string name;
        int    ch;
        int    lvl;
        bit    idle;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic expect_ch(input string name, input int ch, input int lvl, input bit idle, input int offs = 4);
        sb.push_back('{cyc + offs, name, ch, lvl, idle});
    endtask

    task automatic expect_ovr(input string name, input int v, input int offs);
        sb.push_back('{cyc + offs, name, -1, v, 1'b0});
    endtask

    task automatic set_ch(input int ch, input int ar, input int dr, input int sl, input int sr, input int rr);
        reg_ar[ch*RATE_W +: RATE_W] = RATE_W'(ar);
        reg_dr[ch*RATE_W +: RATE_W] = RATE_W'(dr);
        reg_sr[ch*RATE_W +: RATE_W] = RATE_W'(sr);
        reg_rr[ch*RATE_W +: RATE_W] = RATE_W'(rr);
        reg_sl[ch*ENV_W +: ENV_W]   = ENV_W'(sl);
    endtask

    // One 6-clk active period. Keys go with active (gap=0) or on the last clk
    // before the next period (gap=1). dbl re-pulses active 3 clk after the first.
    task automatic do_sweep(input logic [CH-1:0] kon, input logic [CH-1:0] krel,
                            input logic [CH-1:0] koff, input bit gap, input bit dbl);
        active      = 1'b1;
        key_on      = gap ? '0 : kon;
        key_release = gap ? '0 : krel;
        key_off     = gap ? '0 : koff;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            active      = dbl && (k == 3);
            key_on      = (gap && k == 5) ? kon  : '0;
            key_release = (gap && k == 5) ? krel : '0;
            key_off     = (gap && k == 5) ? koff : '0;
        end
        @(posedge clk); #1;
        key_on = '0; key_release = '0; key_off = '0;
    endtask

    task automatic plain_sweep();
        do_sweep('0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic sweeps_check(input int n, input string name, input int ch, input int lvl, input bit idle);
        for (int i = 0; i < n - 1; i++) plain_sweep();
        expect_ch(name, ch, lvl, idle);
        plain_sweep();
    endtask

    // Monitor: compares whenever the DUT reaches a cycle a stimulus step scheduled.
    initial begin : monitor
        exp_t e;
        int   got_l;
        bit   got_i;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if (e.at != cyc) begin
                    $display("FAIL %s: sampled late at cycle %0d, required cycle %0d", e.name, cyc, e.at);
                end else if (e.ch < 0) begin
                    if (int'(overrun) == e.lvl) passed++;
                    else $display("FAIL %s: overrun=%0b required %0d", e.name, overrun, e.lvl);
                end else begin
                    got_l = int'(envelope[e.ch*LVL_W +: LVL_W]);
                    got_i = env_idle[e.ch];
                    if (got_l == e.lvl && got_i == e.idle) passed++;
                    else $display("FAIL %s: ch%0d level=%0d idle=%0b required level=%0d idle=%0b",
                                  e.name, e.ch, got_l, got_i, e.lvl, e.idle);
                end
            end
        end
    end

    initial begin : stimulus
        nreset = 1'b0;
        active = 1'b0;
        key_on = '0; key_release = '0; key_off = '0;
        reg_ar = '0; reg_dr = '0; reg_sr = '0; reg_rr = '0; reg_sl = '0;

        for (int c = 0; c < CH; c++) sb.push_back('{2, "reset_env", c, 0, 1'b1});
        sb.push_back('{2, "reset_ovr", -1, 0, 1'b0});
        repeat (3) @(posedge clk); #1;
        nreset = 1'b1;
        repeat (2) @(posedge clk); #1;

        // 1: fifty empty sweeps
        for (int i = 0; i < 49; i++) plain_sweep();
        for (int c = 0; c < CH; c++) expect_ch("idle_50", c, 0, 1'b1);
        expect_ovr("idle_ovr", 0, 4);
        plain_sweep();

        // 2: instant attack on ch1, event latched until ch1 is reached
        set_ch(1, 0, 0, 0, 0, 0);
        expect_ch("ar0_ch1", 1, 128, 1'b0);
        expect_ch("ar0_ch0", 0, 0, 1'b1);
        expect_ch("ar0_ch2", 2, 0, 1'b1);
        expect_ch("ar0_ch3", 3, 0, 1'b1);
        do_sweep(4'b0010, '0, '0, 1'b0, 1'b0);

        // 5: off beats on; release ignored in IDLE; on at service clk consumed
        set_ch(0, 0, 0, 0, 0, 0);
        expect_ch("on_off_same", 0, 0, 1'b1);
        do_sweep(4'b0001, '0, 4'b0001, 1'b0, 1'b0);
        do_sweep(4'b0001, '0, 4'b0001, 1'b1, 1'b0);
        expect_ch("on_off_pending", 0, 0, 1'b1);
        plain_sweep();
        expect_ch("rel_in_idle", 0, 0, 1'b1);
        do_sweep('0, 4'b0001, '0, 1'b0, 1'b0);
        expect_ch("on_at_service", 0, 128, 1'b0);
        do_sweep(4'b0001, '0, '0, 1'b0, 1'b0);

        // 4: release with RR=0 holds; off clears; on beats release
        set_ch(3, 0, 0, 0, 0, 0);
        expect_ch("ch3_on", 3, 128, 1'b0);
        do_sweep(4'b1000, '0, '0, 1'b0, 1'b0);
        expect_ch("ch3_rel", 3, 128, 1'b0);
        do_sweep('0, 4'b1000, '0, 1'b0, 1'b0);
        for (int i = 0; i < 49; i++) plain_sweep();
        expect_ch("ch3_rel_hold50", 3, 128, 1'b0);
        expect_ch("ch1_dr0_hold", 1, 128, 1'b0);
        plain_sweep();
        expect_ch("ch3_off", 3, 0, 1'b1);
        do_sweep('0, '0, 4'b1000, 1'b0, 1'b0);
        expect_ch("ch3_on_beats_rel", 3, 128, 1'b0);
        do_sweep(4'b1000, 4'b1000, '0, 1'b0, 1'b0);
        expect_ch("ch3_off2", 3, 0, 1'b1);
        do_sweep('0, '0, 4'b1000, 1'b0, 1'b0);

        // 6: overrun; only one step per period
        expect_ch("ch0_rel", 0, 128, 1'b0);
        do_sweep('0, 4'b0001, '0, 1'b0, 1'b0);
        set_ch(0, 0, 0, 0, 0, 1);
`ifdef WTS_ENV_EXP_DECAY_EN
        expect_ovr("ovr_pulse", 1, 4);
        expect_ch("ovr_one_step", 0, 111, 1'b0, 4);
        expect_ovr("ovr_clear", 0, 5);
        expect_ch("ovr_no_2nd_sweep", 0, 111, 1'b0, 6);
        do_sweep('0, '0, '0, 1'b0, 1'b1);
        expect_ch("exp_second_step", 0, 97, 1'b0);
`else
        expect_ovr("ovr_pulse", 1, 4);
        expect_ch("ovr_one_step", 0, 127, 1'b0, 4);
        expect_ovr("ovr_clear", 0, 5);
        expect_ch("ovr_no_2nd_sweep", 0, 127, 1'b0, 6);
        do_sweep('0, '0, '0, 1'b0, 1'b1);
        expect_ch("lin_second_step", 0, 126, 1'b0);
`endif
        plain_sweep();
        expect_ch("ch0_off", 0, 0, 1'b1);
        do_sweep('0, '0, 4'b0001, 1'b0, 1'b0);

`ifndef WTS_ENV_EXP_DECAY_EN
        // 3: full ADSR on ch2 with keys latched between sweeps
        set_ch(2, 2, 3, 100, 100, 4);
        expect_ch("adsr_key_latched", 2, 0, 1'b1);
        do_sweep(4'b0100, '0, '0, 1'b1, 1'b0);
        expect_ch("adsr_attack_enter", 2, 0, 1'b0);
        plain_sweep();
        sweeps_check(255, "attack_255", 2, 127, 1'b0);
        sweeps_check(1, "attack_256", 2, 128, 1'b0);
        sweeps_check(83, "decay_83", 2, 101, 1'b0);
        sweeps_check(1, "decay_84", 2, 100, 1'b0);
        sweeps_check(99, "sustain_99", 2, 100, 1'b0);
        sweeps_check(1, "sustain_100", 2, 99, 1'b0);
        sweeps_check(100, "sustain_200", 2, 98, 1'b0);
        expect_ch("rel_latched", 2, 98, 1'b0);
        do_sweep('0, 4'b0100, '0, 1'b1, 1'b0);
        expect_ch("rel_enter", 2, 98, 1'b0);
        plain_sweep();
        sweeps_check(391, "release_391", 2, 1, 1'b0);
        sweeps_check(1, "release_392", 2, 0, 1'b1);
`endif

        repeat (10) @(posedge clk); #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            $display("FAIL %s: never sampled, got nothing, required cycle %0d", e.name, e.at);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wts_adsr_envelope_generator_mc.md
Name: wts_adsr_envelope_generator_mc

Overview:
Multi-channel, parametrised successor of the single-channel ADSR envelope generator in the wave-table sound core. It holds per-channel envelope state for CH_NUM voices and updates one channel per clk in a sweep triggered by the `active` timing pulse, so every channel advances once per `active` period. It adds per-channel event latching, a sweep-overrun flag, per-channel idle status and an optional exponential decay/release curve. It sits between the register file and the per-voice mixer.

Parameters:
CH_NUM, 4, number of channels; must be ≤ the clk count between `active` pulses.
ENV_W, 7, envelope magnitude bits; maximum level ENV_MAX = 2^ENV_W (128 by default).
RATE_W, 12, width of each AR/DR/SR/RR rate field.

Ports:
clk  in  1  system clock
nreset  in  1  asynchronous active-low reset
active  in  1  single-clk timing pulse (3.579 MHz rate); starts a sweep
key_on  in  CH_NUM  per-channel single-clk pulse
key_release  in  CH_NUM  per-channel single-clk pulse
key_off  in  CH_NUM  per-channel single-clk pulse
reg_ar, reg_dr, reg_sr, reg_rr  in  CH_NUM*RATE_W  rate per channel, flattened; channel c occupies [c*RATE_W +: RATE_W]
reg_sl  in  CH_NUM*ENV_W  sustain level per channel
envelope  out  CH_NUM*(ENV_W+1)  level per channel, 0..ENV_MAX
env_idle  out  CH_NUM  1 when the channel is in phase IDLE
overrun  out  1  single-clk pulse when `active` arrives during a sweep

Behaviour:
- Reset (async, nreset=0): all levels 0, all phases IDLE, all rate counters 0, pending flags 0, sweep idle. Outputs: envelope=0, env_idle=all 1, overrun=0.
- Event latch: a key_* pulse on any clk sets the channel's pending bit. Bits are cleared when that channel is serviced. A pulse arriving on the same clk the channel is serviced is consumed by that service.
- Event priority at service: key_off > key_on > key_release. Lower-priority pending bits are discarded.
- Sweep scheduling:
  - `active` with the sweep idle starts a sweep; channel 0 is serviced on that clk, then channel k on clk+k.
  - Each channel's envelope/env_idle register updates one clk after its service.
  - `active` during a busy sweep is ignored and overrun=1 for one clk.
- Phase transitions at service:
  - key_off: level=0, phase IDLE, counter 0.
  - key_on: phase ATTACK, counter 0. Level is kept (retrigger without click). If AR=0, level=ENV_MAX and phase DECAY on this same service.
  - key_release: phase RELEASE, counter 0. Ignored in IDLE.
- Rate rule for the active phase's rate R:
  - R=0 means hold (no change), except attack as above.
  - Otherwise counter increments each service. When counter+1 == R, one step is applied and counter=0.
- Step actions:
  - ATTACK: level+1; reaching ENV_MAX → DECAY.
  - DECAY: level−1, saturating at SL; when level ≤ SL → SUSTAIN. Entering DECAY with level ≤ SL goes to SUSTAIN without stepping.
  - SUSTAIN: level−1 at SR; reaching 0 → IDLE.
  - RELEASE: level−1 at RR; reaching 0 → IDLE.
- Counter width: RATE_W. Rate fields are sampled at each service, so register changes take effect on the next service.

Optional Feature:
WTS_ENV_EXP_DECAY_EN:
- Defined: DECAY/SUSTAIN/RELEASE step = (level>>3)+1, saturated at the floor (SL for DECAY, 0 otherwise). Attack stays linear.
- Undefined: step = 1 as specified above.

Decomposition:
- Package wts_env_pkg: phase enum (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE, 3 bits); event-priority constants; function env_max(ENV_W).
- Sub-module wts_env_step: combinational next-state calculator for one channel (phase, level, counter, events, rates, SL in → next phase/level/counter out). It holds the WTS_ENV_EXP_DECAY_EN logic.
- Top level: sweep counter, pending flags, per-channel state arrays, output registers.

Test Plan:
All scenarios use CH_NUM=4, ENV_W=7, RATE_W=12, `active` every 6 clk.
1. Reset then 50 sweeps with no keys → all envelope=0, env_idle=4'b1111, overrun=0.
2. ch1 AR=0, key_on[1] → after next sweep envelope[ch1]=128, env_idle[1]=0; ch0/2/3 stay 0.
3. ch2 AR=2, DR=3, SL=100, SR=100, RR=4, key_on[2]:
   - level=128 after 256 sweeps;
   - level=100 after a further 84 sweeps;
   - then −1 per 100 sweeps;
   - key_release → −1 per 4 sweeps to 0, env_idle[2]=1.
4. ch3 at 128 with RR=0: key_release → level held at 128 for 50 sweeps; key_off → 0 after next sweep.
5. key_on[0] and key_off[0] on the same clk (AR=0) → ch0 stays 0 and IDLE. key_on[0] on the clk ch0 is serviced → consumed in that sweep.
6. Two `active` pulses 3 clk apart → overrun pulses once, second sweep not started, levels advance by one step only. With WTS_ENV_EXP_DECAY_EN, level 128 RR=1 → 111 after one sweep.
